// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: oversampled UART receiver with configurable framing
// feeding a first-word-fall-through byte FIFO with per-entry error tags.

module uart_rx_fifo #(
  parameter int data_bits   = 8,
  parameter int parity_mode = 0,
  parameter int stop_bits   = 1,
  parameter int scaler      = 8,
  parameter int fifo_log2   = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [15:0]        i_div,
  input  logic               i_rx,
  output logic [7:0]         o_rdata,
  output logic [1:0]         o_rerr,
  output logic               o_rvalid,
  input  logic               i_rready,
  output logic [fifo_log2:0] o_count,
  output logic               o_overflow,
  input  logic               i_clr_ovf,
  output logic               o_busy
);

  localparam int SW    = $clog2(scaler);
  localparam int DEPTH = 1 << fifo_log2;

  typedef logic [SW-1:0]        smp_t;
  typedef logic [fifo_log2-1:0] ptr_t;
  typedef logic [fifo_log2:0]   cnt_t;

  localparam smp_t       SMP_HALF  = smp_t'(scaler / 2 - 1);
  localparam smp_t       SMP_FULL  = smp_t'(scaler - 1);
  localparam logic [2:0] LAST_DATA = 3'(data_bits - 1);
  localparam logic [2:0] LAST_STOP = 3'(stop_bits - 1);
  localparam logic       ODD       = (parity_mode == 1);
  localparam logic       HAS_PAR   = (parity_mode != 0);
  localparam cnt_t       FULL      = cnt_t'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic sync_q, rxs_q, prev_q;

  state_t               state_q, state_d;
  logic [15:0]          div_cnt_q, div_cnt_d;
  logic [15:0]          div_lat_q, div_lat_d;
  smp_t                 smp_cnt_q, smp_cnt_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [data_bits-1:0] data_q, data_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;

  logic       tick, smp;
  logic       push;
  logic [9:0] push_word;

  logic [9:0] mem_q [DEPTH];
  logic [9:0] mem_d [DEPTH];
  ptr_t       wr_ptr_q, wr_ptr_d;
  ptr_t       rd_ptr_q, rd_ptr_d;
  cnt_t       count_q, count_d;
  logic       ovf_q, ovf_d;
  logic       pop, wr;

  // two-flop synchroniser plus previous sample for falling-edge detect
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= 1'b1;
      rxs_q  <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= i_rx;
      rxs_q  <= sync_q;
      prev_q <= rxs_q;
    end
  end

  // sample tick from the latched divider, and the mid-bit sample strobe
  always_comb begin
    tick = 1'b0;
    smp  = 1'b0;
    if (state_q != S_IDLE) begin
      tick = (div_cnt_q == div_lat_q);
    end
    if (tick) begin
      smp = (smp_cnt_q == ((state_q == S_START) ? SMP_HALF : SMP_FULL));
    end
  end

  // receive FSM: next state, shift register, error flags, push strobe
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    div_lat_d = div_lat_q;
    smp_cnt_d = smp_cnt_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    push      = 1'b0;
    push_word = {perr_q, ferr_q | ~rxs_q, 8'(data_q)};

    if (state_q != S_IDLE) begin
      div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
      if (tick) begin
        smp_cnt_d = smp ? smp_t'(0) : smp_cnt_q + smp_t'(1);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        div_cnt_d = 16'd0;
        smp_cnt_d = smp_t'(0);
        if (prev_q && !rxs_q) begin
          state_d   = S_START;
          div_lat_d = i_div;
          bit_cnt_d = 3'd0;
          data_d    = '0;
          perr_d    = 1'b0;
          ferr_d    = 1'b0;
        end
      end
      S_START: begin
        if (smp) begin
          state_d   = rxs_q ? S_IDLE : S_DATA;
          bit_cnt_d = 3'd0;
        end
      end
      S_DATA: begin
        if (smp) begin
          data_d = {rxs_q, data_q[data_bits-1:1]};
          if (bit_cnt_q == LAST_DATA) begin
            bit_cnt_d = 3'd0;
            state_d   = HAS_PAR ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (smp) begin
          perr_d  = ((^data_q) ^ rxs_q) != ODD;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (smp) begin
          ferr_d = ferr_q | ~rxs_q;
          if (bit_cnt_q == LAST_STOP) begin
            push    = 1'b1;
            state_d = S_IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // receive FSM registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      div_cnt_q <= 16'd0;
      div_lat_q <= 16'd0;
      smp_cnt_q <= smp_t'(0);
      bit_cnt_q <= 3'd0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      div_lat_q <= div_lat_d;
      smp_cnt_q <= smp_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      data_q    <= data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  // FIFO control: a pop frees the head slot so a full FIFO can still accept
  always_comb begin
    pop      = (count_q != '0) && i_rready;
    wr       = push && ((count_q != FULL) || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + cnt_t'(wr) - cnt_t'(pop);
    ovf_d    = ovf_q;
    if (wr) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (push && !wr) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= ptr_t'(0);
      rd_ptr_q <= ptr_t'(0);
      count_q  <= cnt_t'(0);
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents are don't-care while not counted
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

  assign o_rvalid   = (count_q != '0);
  assign o_rdata    = o_rvalid ? mem_q[rd_ptr_q][7:0] : 8'd0;
  assign o_rerr     = o_rvalid ? mem_q[rd_ptr_q][9:8] : 2'd0;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and randomized frames on three
// configurations, checked against a frame/queue reference model.

module tb_uart_rx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  rx, rready, clr;
  logic [15:0] div0, div1, div2;

  logic [7:0] rdata0, rdata1, rdata2;
  logic [1:0] rerr0, rerr1, rerr2;
  logic       rvalid0, rvalid1, rvalid2;
  logic [4:0] count0, count1;
  logic [2:0] count2;
  logic       ovf0, ovf1, ovf2;
  logic       busy0, busy1, busy2;

  uart_rx_fifo u0 (
    .i_clk(clk), .i_rst(rst), .i_div(div0), .i_rx(rx[0]),
    .o_rdata(rdata0), .o_rerr(rerr0), .o_rvalid(rvalid0),
    .i_rready(rready[0]), .o_count(count0), .o_overflow(ovf0),
    .i_clr_ovf(clr[0]), .o_busy(busy0)
  );

  uart_rx_fifo #(
    .data_bits(7), .parity_mode(2), .stop_bits(2)
  ) u1 (
    .i_clk(clk), .i_rst(rst), .i_div(div1), .i_rx(rx[1]),
    .o_rdata(rdata1), .o_rerr(rerr1), .o_rvalid(rvalid1),
    .i_rready(rready[1]), .o_count(count1), .o_overflow(ovf1),
    .i_clr_ovf(clr[1]), .o_busy(busy1)
  );

  uart_rx_fifo #(
    .fifo_log2(2)
  ) u2 (
    .i_clk(clk), .i_rst(rst), .i_div(div2), .i_rx(rx[2]),
    .o_rdata(rdata2), .o_rerr(rerr2), .o_rvalid(rvalid2),
    .i_rready(rready[2]), .o_count(count2), .o_overflow(ovf2),
    .i_clr_ovf(clr[2]), .o_busy(busy2)
  );

  int total = 0;
  int bad   = 0;
  int lat_n;

  logic [15:0] fb;
  int          fn;
  logic [9:0]  q0 [$];
  logic [9:0]  q2 [$];
  logic [9:0]  e;
  logic        ovf_m;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // line levels of one frame, LSB first, plus the entry it should produce
  function automatic void mk_frame(
    input logic [7:0] d, input int nd, input int pm, input int ns,
    input bit bp, input bit bs,
    output logic [15:0] b, output int n, output logic [9:0] ent);
    logic [7:0] m;
    logic       par;
    m = d & 8'((1 << nd) - 1);
    b = '1;
    n = 0;
    b[n] = 1'b0;
    n++;
    for (int i = 0; i < nd; i++) begin
      b[n] = m[i];
      n++;
    end
    if (pm != 0) begin
      par = ^m;
      if (pm == 1) par = ~par;
      b[n] = par ^ bp;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      b[n] = (i == 0) ? ~bs : 1'b1;
      n++;
    end
    ent = {(pm != 0) && bp, bs, m};
  endfunction

  // clocks from start-bit drive to entry visible, scaler 8
  function automatic int lat(input int nf, input int dv);
    return 3 + (4 + (nf - 1) * 8) * (dv + 1);
  endfunction

  task automatic send_bits(input int u, input logic [15:0] b,
                           input int n, input int dv);
    for (int i = 0; i < n; i++) begin
      rx[u] = b[i];
      repeat (8 * (dv + 1)) @(posedge clk);
      #1;
    end
    rx[u] = 1'b1;
  endtask

  // send on u0 while timing the entry and disturbing i_div mid-frame
  task automatic send0_timed(input logic [15:0] b, input int n,
                             input int dv, input int target);
    lat_n = 0;
    fork
      send_bits(0, b, n, dv);
      begin
        while (32'(count0) != target && lat_n < 4000) begin
          @(posedge clk);
          #1;
          lat_n++;
        end
      end
      begin
        repeat (12) @(posedge clk);
        #1;
        div0 = 16'($urandom_range(0, 7));
      end
    join
  endtask

  task automatic pop_one(input int u);
    rready[u] = 1'b1;
    step(1);
    rready[u] = 1'b0;
  endtask

  task automatic run1(input logic [7:0] d, input bit bp, input bit bs);
    mk_frame(d, 7, 2, 2, bp, bs, fb, fn, e);
    send_bits(1, fb, fn, 3);
    step(3);
    chk("p7_valid", 32'(rvalid1), 32'd1);
    chk("p7_data", 32'(rdata1), 32'(e[7:0]));
    chk("p7_err", 32'(rerr1), 32'(e[9:8]));
    pop_one(1);
    chk("p7_empty", 32'(count1), 32'd0);
  endtask

  task automatic send2(input logic [7:0] d);
    mk_frame(d, 8, 0, 1, 1'b0, 1'b0, fb, fn, e);
    send_bits(2, fb, fn, 0);
    step(3);
    if (q2.size() < 4) q2.push_back(e);
    else ovf_m = 1'b1;
  endtask

  task automatic drain2(input string tag);
    while (q2.size() > 0) begin
      chk(tag, 32'(rdata2), 32'(q2[0][7:0]));
      pop_one(2);
      void'(q2.pop_front());
    end
    chk("fifo_drained", 32'(count2), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    int         dv;
    bit         bs;
    int         n_b;

    rx     = '1;
    rready = '0;
    clr    = '0;
    div0   = 16'd0;
    div1   = 16'd3;
    div2   = 16'd0;
    rst    = 1'b1;
    ovf_m  = 1'b0;
    step(3);
    rst = 1'b0;
    step(1);

    chk("rst_rdata", 32'(rdata0), 32'd0);
    chk("rst_rerr", 32'(rerr0), 32'd0);
    chk("rst_rvalid", 32'(rvalid0), 32'd0);
    chk("rst_count", 32'(count0), 32'd0);
    chk("rst_ovf", 32'(ovf0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_count2", 32'(count2), 32'd0);

    mk_frame(8'hA5, 8, 0, 1, 1'b0, 1'b0, fb, fn, e);
    div0 = 16'd0;
    send0_timed(fb, fn, 0, 1);
    chk("a5_latency", 32'(lat_n), 32'd79);
    chk("a5_data", 32'(rdata0), 32'hA5);
    chk("a5_err", 32'(rerr0), 32'd0);
    chk("a5_count", 32'(count0), 32'd1);
    pop_one(0);
    chk("a5_popped", 32'(count0), 32'd0);
    step(4);

    div0  = 16'd0;
    rx[0] = 1'b0;
    step(2);
    rx[0] = 1'b1;
    step(1);
    chk("glitch_busy", 32'(busy0), 32'd1);
    n_b = 0;
    while (busy0 && n_b < 20) begin
      step(1);
      n_b++;
    end
    chk("glitch_idle", 32'(n_b <= 5), 32'd1);
    step(10);
    chk("glitch_count", 32'(count0), 32'd0);

    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < 2; k++) begin
        d  = 8'($urandom);
        dv = $urandom_range(0, 3);
        bs = ($urandom_range(0, 3) == 0);
        mk_frame(d, 8, 0, 1, 1'b0, bs, fb, fn, e);
        q0.push_back(e);
        div0 = 16'(dv);
        send0_timed(fb, fn, dv, q0.size());
        chk("rnd_latency", 32'(lat_n), 32'(lat(fn, dv)));
        step(3);
      end
      while (q0.size() > 0) begin
        e = q0.pop_front();
        chk("rnd_data", 32'(rdata0), 32'(e[7:0]));
        chk("rnd_err", 32'(rerr0), 32'(e[9:8]));
        pop_one(0);
      end
      chk("rnd_empty", 32'(count0), 32'd0);
    end

    run1(8'h41, 1'b0, 1'b0);
    run1(8'h41, 1'b1, 1'b0);
    run1(8'hC1, 1'b0, 1'b1);

    for (int v = 1; v <= 5; v++) send2(8'(v));
    chk("ovf_count", 32'(count2), 32'(q2.size()));
    chk("ovf_set", 32'(ovf2), 32'(ovf_m));
    drain2("ovf_order");
    clr[2] = 1'b1;
    step(1);
    clr[2] = 1'b0;
    ovf_m  = 1'b0;
    chk("ovf_clr", 32'(ovf2), 32'd0);

    for (int v = 1; v <= 4; v++) send2(8'(v));
    mk_frame(8'h05, 8, 0, 1, 1'b0, 1'b0, fb, fn, e);
    fork
      send_bits(2, fb, fn, 0);
      begin
        repeat (lat(fn, 0) - 1) @(posedge clk);
        #1;
        rready[2] = 1'b1;
        step(1);
        rready[2] = 1'b0;
      end
    join
    step(3);
    void'(q2.pop_front());
    q2.push_back(e);
    chk("fullpp_count", 32'(count2), 32'(q2.size()));
    chk("fullpp_ovf", 32'(ovf2), 32'd0);
    drain2("fullpp_order");

    div0 = 16'd0;
    mk_frame(8'h77, 8, 0, 1, 1'b0, 1'b0, fb, fn, e);
    send_bits(0, fb, fn, 0);
    step(3);
    chk("pre_rst_count", 32'(count0), 32'd1);
    mk_frame(8'h3C, 8, 0, 1, 1'b0, 1'b0, fb, fn, e);
    send_bits(0, fb, 4, 0);
    chk("pre_rst_busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(3);
    chk("post_rst_busy", 32'(busy0), 32'd0);
    chk("post_rst_valid", 32'(rvalid0), 32'd0);
    chk("post_rst_count", 32'(count0), 32'd0);
    mk_frame(8'h5A, 8, 0, 1, 1'b0, 1'b0, fb, fn, e);
    div0 = 16'd0;
    send0_timed(fb, fn, 0, 1);
    chk("after_rst_lat", 32'(lat_n), 32'd79);
    chk("after_rst_data", 32'(rdata0), 32'h5A);
    chk("after_rst_err", 32'(rerr0), 32'd0);
    chk("after_rst_count", 32'(count0), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Parametrised, buffered UART receiver for the kc705 SoC console path and for bench monitoring of the UART1 TX line.
- Generalises the fixed 8N1, scaler-8 receive path: configurable data bits, parity mode, stop bits and oversampling.
- Adds a runtime baud divider, per-byte error tagging and a FIFO with overflow tracking.

Parameters:
data_bits, 8, payload bits per frame (5..8), LSB first
parity_mode, 0, 0=none, 1=odd, 2=even
stop_bits, 1, stop bits checked (1 or 2)
scaler, 8, sample ticks per bit (even, >=4)
fifo_log2, 4, FIFO depth = 2**fifo_log2 entries

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_div  in  16  sample tick every i_div+1 clocks; latched at start-bit detection
i_rx  in  1  serial input (asynchronous, idle high)
o_rdata  out  8  FIFO head byte, zero-extended above data_bits
o_rerr  out  2  FIFO head flags: [0]=frame error, [1]=parity error
o_rvalid  out  1  FIFO non-empty
i_rready  in  1  pop head when o_rvalid=1
o_count  out  fifo_log2+1  entries held (0..2**fifo_log2)
o_overflow  out  1  sticky: a completed frame was dropped on a full FIFO
i_clr_ovf  in  1  clears o_overflow
o_busy  out  1  receive FSM not in IDLE

Behaviour:
- Reset: every output 0; i_rx synchroniser and previous-sample register set to 1; FSM IDLE; FIFO empty.
  - Reset mid-frame discards the partial frame and all FIFO contents.
- Synchroniser: i_rx passes 2 flops; rxs denotes its output.
- Sample tick: divider counts 0..div_lat and pulses on reaching div_lat.
  - Divider is held at 0 in IDLE.
  - i_div changes mid-frame have no effect until the next start.
- FSM IDLE: rxs falling edge (prev=1, now 0) -> START; latch i_div; clear sample counter.
- FSM START: on tick count scaler/2, sample rxs.
  - rxs=1: false start -> IDLE, nothing pushed.
  - rxs=0: -> DATA with bit index 0.
- Sample point: every bit after START is sampled `scaler` ticks after the previous sample, i.e. mid-bit.
- FSM DATA: shift rxs in LSB first; after data_bits samples -> PARITY if parity_mode!=0, else STOP.
- FSM PARITY: sample rxs.
  - parity_err=1 when XOR(data,rxs) differs from the mode: odd requires XOR=1, even requires XOR=0.
  - Then -> STOP.
- FSM STOP: sample rxs; frame_err |= (rxs==0).
  - stop_bits=2: a second stop sample follows.
  - After the last stop sample: push {flags,data}, then -> IDLE in the same cycle.
  - A new falling edge is accepted from the next clock; a break (rxs held 0) therefore does not retrigger.
- Error frames are pushed, tagged in o_rerr, never dropped.
- Push latency: the entry is visible on o_rvalid/o_rdata 1 clock after the last stop sample.
- FIFO is first-word-fall-through; pop occurs when o_rvalid & i_rready.
  - Push while full, no pop: entry dropped, o_overflow<=1, count unchanged.
  - Push and pop in the same clock while full: both accepted, count unchanged.
  - Push and pop in the same clock while non-empty: count unchanged, order preserved.
  - Pop while empty: ignored.
  - Pointers wrap modulo 2**fifo_log2.
- i_clr_ovf coincident with a new overflow: set wins.
- o_busy=1 in START/DATA/PARITY/STOP.

Test Plan:
- Default params, i_div=0 (8 clk/bit), send 0xA5 8N1: o_rvalid rises 79 clocks after the i_rx falling edge (2 sync + 4 + 9*8 + 1), o_rdata=0xA5, o_rerr=00; pop with i_rready -> o_count 1->0.
- Glitch: i_rx low for 2 clocks then high: no push, o_busy returns to 0 within 6 clocks, o_count=0.
- data_bits=7, parity_mode=2, stop_bits=2, i_div=3: send 0x41 with correct parity (0) -> o_rdata=0x41, o_rerr=00; resend with parity bit 1 -> o_rerr=10; stop bit forced 0 -> o_rerr[0]=1.
- fifo_log2=2, i_rready=0, send 5 bytes 0x01..0x05: o_count=4, o_overflow=1, then pops return 0x01..0x04; i_clr_ovf -> o_overflow=0.
- FIFO full with i_rready held 1 during the 5th frame's push cycle: o_count stays 4, no overflow, order 0x02..0x05 after the pop.
- Assert i_rst during DATA of byte 0x3C and release: o_busy=0, o_rvalid=0, o_count=0; the next clean 0x5A is received correctly.
